// File: rtl/ttt_pkg.sv
// Shared types, constants and board helpers for the tic-tac-toe move engine.
package ttt_pkg;

    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    localparam int unsigned MAX_CELLS   = 64;
    localparam int unsigned MAX_ID_W    = 8;
    localparam int unsigned MAX_BOARD_W = MAX_CELLS * MAX_ID_W;

    localparam logic [MAX_ID_W-1:0] EMPTY_ID  = '0;
    localparam logic [7:0]          LFSR_TAPS = 8'hB8;

    // Board is passed zero-extended to the widest legal size so one helper serves every build.
    function automatic logic [MAX_ID_W-1:0] cell_get(input logic [MAX_BOARD_W-1:0] board,
                                                     input int unsigned            i,
                                                     input int unsigned            id_w);
        logic [MAX_BOARD_W-1:0] shifted;
        logic [MAX_ID_W-1:0]    mask;
        shifted = board >> (i * id_w);
        mask    = MAX_ID_W'((1 << id_w) - 1);
        return shifted[MAX_ID_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/ttt_lfsr8.sv
// Free-running 8-bit Galois LFSR used to pick the scan start cell.
module ttt_lfsr8
    import ttt_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] value
);

    logic [7:0] lfsr_d;
    logic [7:0] lfsr_q;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/ttt_move_engine.sv
// Board-owning move engine: human write port plus a one-cell-per-cycle machine move scan.
module ttt_move_engine
    import ttt_pkg::*;
#(
    parameter int unsigned N_CELLS   = 9,
    parameter int unsigned ID_W      = 2,
    parameter bit          RANDOM_EN = 1'b1,
    parameter logic [7:0]  LFSR_SEED = 8'h01,
    localparam int unsigned POS_W    = $clog2(N_CELLS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [POS_W-1:0]        wr_pos,
    input  logic [ID_W-1:0]         wr_id,
    output logic                    wr_err,
    input  logic                    req,
    input  logic [ID_W-1:0]         ai_id,
    output logic                    busy,
    output logic                    done,
    output logic                    no_move,
    output logic [POS_W-1:0]        position,
    output logic [N_CELLS*ID_W-1:0] board
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_CELLS - 1);
    localparam logic [ID_W-1:0]  EMPTY    = ID_W'(EMPTY_ID);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   cells_q [N_CELLS];
    logic [ID_W-1:0]   cells_d [N_CELLS];
    logic [POS_W-1:0]  idx_q, idx_d;
    logic [POS_W-1:0]  cnt_q, cnt_d;
    logic [POS_W-1:0]  position_q, position_d;
    logic [ID_W-1:0]   ai_id_q, ai_id_d;
    logic              done_q, done_d;
    logic              no_move_q, no_move_d;
    logic              wr_err_q, wr_err_d;

    logic [7:0]        lfsr;
    logic [POS_W-1:0]  start_pos;
    logic [ID_W-1:0]   scan_cell;
    logic [ID_W-1:0]   wr_cell;
    logic              wr_ok;

    ttt_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr)
    );

    for (genvar g = 0; g < N_CELLS; g++) begin : g_pack
        assign board[g*ID_W +: ID_W] = cells_q[g];
    end

    assign start_pos = RANDOM_EN ? POS_W'(32'(lfsr) % N_CELLS) : '0;
    assign scan_cell = ID_W'(cell_get(MAX_BOARD_W'(board), 32'(idx_q), ID_W));
    assign wr_cell   = ID_W'(cell_get(MAX_BOARD_W'(board), 32'(wr_pos), ID_W));
    assign wr_ok     = (32'(wr_pos) < N_CELLS) && (wr_id != EMPTY) && (wr_cell == EMPTY);

    always_comb begin
        state_d    = state_q;
        cells_d    = cells_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        position_d = position_q;
        ai_id_d    = ai_id_q;
        done_d     = 1'b0;
        no_move_d  = 1'b0;
        wr_err_d   = 1'b0;

        if (clear) begin
            cells_d = '{default: '0};
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // A write and a request in the same cycle: the scan starts on the updated board.
                    if (wr_en) begin
                        if (wr_ok) begin
                            cells_d[wr_pos] = wr_id;
                        end else begin
                            wr_err_d = 1'b1;
                        end
                    end
                    if (req) begin
                        ai_id_d = ai_id;
                        idx_d   = start_pos;
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    wr_err_d = wr_en;
                    if (scan_cell == EMPTY) begin
                        cells_d[idx_q] = ai_id_q;
                        position_d     = idx_q;
                        done_d         = 1'b1;
                        state_d        = IDLE;
                    end else if (cnt_q == LAST_POS) begin
                        done_d    = 1'b1;
                        no_move_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        idx_d = (idx_q == LAST_POS) ? '0 : idx_q + POS_W'(1);
                        cnt_d = cnt_q + POS_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cells_q    <= '{default: '0};
            idx_q      <= '0;
            cnt_q      <= '0;
            position_q <= '0;
            ai_id_q    <= '0;
            done_q     <= 1'b0;
            no_move_q  <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cells_q    <= cells_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            position_q <= position_d;
            ai_id_q    <= ai_id_d;
            done_q     <= done_d;
            no_move_q  <= no_move_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign busy     = (state_q == SCAN);
    assign done     = done_q;
    assign no_move  = no_move_q;
    assign wr_err   = wr_err_q;
    assign position = position_q;

endmodule

// File: tb/tb_ttt_move_engine.sv
// Bench for ttt_move_engine: fixed-order 9-cell build (dut_a) and LFSR-start 16-cell build (dut_b).
module tb_ttt_move_engine;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       a_clear = 0, a_wr_en = 0, a_req = 0;
    logic [3:0] a_wr_pos = 0;
    logic [1:0] a_wr_id = 0, a_ai_id = 0;
    logic       a_wr_err, a_busy, a_done, a_no_move;
    logic [3:0] a_position;
    logic [17:0] a_board;

    logic       b_clear = 0, b_wr_en = 0, b_req = 0;
    logic [3:0] b_wr_pos = 0;
    logic [1:0] b_wr_id = 0, b_ai_id = 0;
    logic       b_wr_err, b_busy, b_done, b_no_move;
    logic [3:0] b_position;
    logic [31:0] b_board;

    ttt_move_engine #(.N_CELLS(9), .ID_W(2), .RANDOM_EN(1'b0), .LFSR_SEED(8'h01)) dut_a (
        .clock(clock), .reset(reset), .clear(a_clear), .wr_en(a_wr_en), .wr_pos(a_wr_pos),
        .wr_id(a_wr_id), .wr_err(a_wr_err), .req(a_req), .ai_id(a_ai_id), .busy(a_busy),
        .done(a_done), .no_move(a_no_move), .position(a_position), .board(a_board)
    );

    ttt_move_engine #(.N_CELLS(16), .ID_W(2), .RANDOM_EN(1'b1), .LFSR_SEED(8'h01)) dut_b (
        .clock(clock), .reset(reset), .clear(b_clear), .wr_en(b_wr_en), .wr_pos(b_wr_pos),
        .wr_id(b_wr_id), .wr_err(b_wr_err), .req(b_req), .ai_id(b_ai_id), .busy(b_busy),
        .done(b_done), .no_move(b_no_move), .position(b_position), .board(b_board)
    );

    typedef struct { int pos; bit no_move; int lat; } exp_t;
    typedef struct { bit is_req; logic [3:0] pos; logic [1:0] id; bit exp_err; } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [1:0] ma [9];
    logic [1:0] mb [16];
    int a_last_pos = 0;
    int b_last_pos = 0;
    int total = 0;
    int bad = 0;

    // Reference LFSR: x^8+x^6+x^5+x^4+1 Galois form, seeded at reset.
    logic [7:0] m_lfsr;
    always @(posedge clock or posedge reset) begin
        if (reset) m_lfsr <= 8'h01;
        else       m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [17:0] pack_a();
        logic [17:0] r;
        for (int i = 0; i < 9; i++) r[i*2 +: 2] = ma[i];
        return r;
    endfunction

    function automatic logic [31:0] pack_b();
        logic [31:0] r;
        for (int i = 0; i < 16; i++) r[i*2 +: 2] = mb[i];
        return r;
    endfunction

    function automatic logic [63:0] occ_a();
        logic [63:0] r = '0;
        for (int i = 0; i < 9; i++) r[i] = (ma[i] != 0);
        return r;
    endfunction

    function automatic logic [63:0] occ_b();
        logic [63:0] r = '0;
        for (int i = 0; i < 16; i++) r[i] = (mb[i] != 0);
        return r;
    endfunction

    function automatic exp_t model_scan(input logic [63:0] occ, input int n, input int start,
                                        input int prev_pos);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int c;
            c = (start + k) % n;
            if (!occ[c]) begin
                e.pos = c; e.no_move = 1'b0; e.lat = k + 1;
                return e;
            end
        end
        e.pos = prev_pos; e.no_move = 1'b1; e.lat = n;
        return e;
    endfunction

    task automatic a_write(input logic [3:0] pos, input logic [1:0] id, input bit exp_err,
                           input string tag);
        a_wr_en = 1; a_wr_pos = pos; a_wr_id = id;
        cyc();
        a_wr_en = 0;
        check({tag, " wr_err"}, a_wr_err, exp_err);
        if (!exp_err) ma[pos] = id;
        check({tag, " board"}, a_board, pack_a());
        cyc();
        check({tag, " wr_err pulse"}, a_wr_err, 0);
    endtask

    task automatic a_clear_board();
        a_clear = 1;
        cyc();
        a_clear = 0;
        foreach (ma[i]) ma[i] = 0;
    endtask

    // co_pos: human write in the request cycle; busy_wr: write attempted during the scan;
    // clear_at: abort the scan with clear at that cycle (no done expected).
    task automatic a_request(input logic [1:0] ai, input int co_pos, input int busy_wr,
                             input int clear_at, input string tag);
        exp_t e;
        exp_t got;
        int   busy_n;
        int   lat;
        bit   seen_done;
        a_req = 1; a_ai_id = ai;
        if (co_pos >= 0) begin
            a_wr_en = 1; a_wr_pos = 4'(co_pos); a_wr_id = 1; ma[co_pos] = 1;
        end
        e = model_scan(occ_a(), 9, 0, a_last_pos);
        if (clear_at == 0) qa.push_back(e);
        cyc();
        a_req = 0; a_wr_en = 0;
        check({tag, " busy after req"}, a_busy, 1);
        busy_n = 1; lat = 0; seen_done = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == clear_at) a_clear = 1;
            if (c == 1 && busy_wr >= 0) begin
                a_wr_en = 1; a_wr_pos = 4'(busy_wr); a_wr_id = 1;
            end
            cyc();
            a_clear = 0;
            if (c == clear_at) foreach (ma[i]) ma[i] = 0;
            if (c == 1 && busy_wr >= 0) begin
                a_wr_en = 0;
                check({tag, " wr_err while busy"}, a_wr_err, 1);
                check({tag, " board after busy write"}, a_board, pack_a());
            end
            if (a_done) begin
                seen_done = 1; lat = c;
                break;
            end
            if (a_busy) busy_n++;
        end
        if (clear_at > 0) begin
            check({tag, " no done after clear"}, seen_done, 0);
            check({tag, " idle after clear"}, a_busy, 0);
            check({tag, " board cleared"}, a_board, pack_a());
            check({tag, " position held"}, a_position, a_last_pos);
        end else begin
            check({tag, " done seen"}, seen_done, 1);
            if (qa.size() > 0) begin
                got = qa.pop_front();
                if (seen_done) begin
                    check({tag, " latency"}, lat, got.lat);
                    check({tag, " busy cycles"}, busy_n, got.lat);
                    check({tag, " busy low at done"}, a_busy, 0);
                    check({tag, " no_move"}, a_no_move, got.no_move);
                    check({tag, " position"}, a_position, got.pos);
                    if (!got.no_move) begin
                        ma[got.pos] = ai;
                        a_last_pos  = got.pos;
                    end
                    check({tag, " board"}, a_board, pack_a());
                    cyc();
                    check({tag, " done pulse"}, {a_done, a_no_move}, 2'b00);
                end
            end
        end
    endtask

    task automatic b_write(input logic [3:0] pos, input logic [1:0] id);
        b_wr_en = 1; b_wr_pos = pos; b_wr_id = id;
        cyc();
        b_wr_en = 0;
        mb[pos] = id;
        check("b human write wr_err", b_wr_err, 0);
    endtask

    vec_t tbl[15];
    logic [15:0] seen_start;

    initial begin
        tbl[0]  = '{0, 4'd0,  2'd1, 0};
        tbl[1]  = '{0, 4'd1,  2'd1, 0};
        tbl[2]  = '{1, 4'd0,  2'd2, 0};  // claims cell 2 after three cycles
        tbl[3]  = '{0, 4'd1,  2'd3, 1};  // occupied
        tbl[4]  = '{0, 4'd9,  2'd1, 1};  // off the board
        tbl[5]  = '{0, 4'd15, 2'd1, 1};
        tbl[6]  = '{0, 4'd4,  2'd0, 1};  // empty ID
        tbl[7]  = '{0, 4'd3,  2'd1, 0};
        tbl[8]  = '{0, 4'd4,  2'd1, 0};
        tbl[9]  = '{0, 4'd5,  2'd1, 0};
        tbl[10] = '{0, 4'd6,  2'd1, 0};
        tbl[11] = '{0, 4'd7,  2'd1, 0};
        tbl[12] = '{0, 4'd8,  2'd3, 0};
        tbl[13] = '{1, 4'd0,  2'd3, 0};  // full board: no_move after 9 cycles
        tbl[14] = '{0, 4'd5,  2'd2, 1};
        foreach (ma[i]) ma[i] = 0;
        foreach (mb[i]) mb[i] = 0;
        seen_start = '0;

        repeat (3) @(posedge clock);
        #1 reset = 0;
        check("reset a board", a_board, 0);
        check("reset a flags", {a_busy, a_done, a_no_move, a_wr_err}, 4'b0000);
        check("reset a position", a_position, 0);
        check("reset b board", b_board, 0);
        check("reset b flags", {b_busy, b_done, b_no_move, b_wr_err}, 4'b0000);

        a_request(2'd2, -1, -1, 0, "a empty");
        a_clear_board();
        check("a clear idle", a_board, 0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].is_req) a_request(tbl[i].id, -1, -1, 0, $sformatf("vec%0d req", i));
            else a_write(tbl[i].pos, tbl[i].id, tbl[i].exp_err, $sformatf("vec%0d wr", i));
        end

        a_clear_board();
        for (int i = 0; i < 4; i++) a_write(4'(i), 2'd1, 0, "a prefill4");
        a_request(2'd3, -1, 7, 0, "a busy write");

        a_clear_board();
        a_request(2'd2, 0, -1, 0, "a write+req");

        a_clear_board();
        for (int i = 0; i < 8; i++) a_write(4'(i), 2'd1, 0, "a prefill8");
        a_request(2'd2, -1, -1, 2, "a abort");

        // clear beats a same-cycle write and request
        a_write(4'd2, 2'd1, 0, "a pre clear");
        a_clear = 1; a_wr_en = 1; a_wr_pos = 4'd4; a_wr_id = 2'd1; a_req = 1; a_ai_id = 2'd2;
        cyc();
        a_clear = 0; a_wr_en = 0; a_req = 0;
        foreach (ma[i]) ma[i] = 0;
        check("clear+wr wr_err", a_wr_err, 0);
        check("clear+wr board", a_board, pack_a());
        check("clear+req busy", a_busy, 0);
        cyc();
        check("clear+req no done", {a_done, a_busy, a_wr_err}, 3'b000);

        // dut_b: random start, sparse board kept by periodic clears
        b_write(4'd5, 2'd1);
        b_write(4'd10, 2'd1);
        for (int n = 0; n < 200; n++) begin
            exp_t e;
            exp_t got;
            int   start;
            int   lat;
            int   ones;
            logic [1:0] ai;
            ones = $countones(occ_b());
            if (ones >= 8) begin
                b_clear = 1; cyc(); b_clear = 0;
                foreach (mb[i]) mb[i] = 0;
                b_write(4'd5, 2'd1);
                b_write(4'd10, 2'd1);
            end
            repeat ($urandom_range(0, 3)) cyc();
            ai    = 2'($urandom_range(1, 3));
            start = int'(m_lfsr) % 16;
            seen_start[start] = 1'b1;
            qb.push_back(model_scan(occ_b(), 16, start, b_last_pos));
            b_req = 1; b_ai_id = ai;
            cyc();
            b_req = 0;
            lat = 0;
            for (int c = 1; c <= 20; c++) begin
                cyc();
                if (b_done) begin
                    lat = c;
                    break;
                end
            end
            check("b done seen", lat != 0, 1);
            got = qb.pop_front();
            if (lat != 0) begin
                check($sformatf("b req%0d position", n), b_position, got.pos);
                check($sformatf("b req%0d latency", n), lat, got.lat);
                check($sformatf("b req%0d no_move/busy", n), {b_no_move, b_busy}, 2'b00);
                mb[got.pos] = ai;
                b_last_pos  = got.pos;
            end
        end
        check("b final board", b_board, pack_b());
        check("b all start indices", seen_start, 16'hFFFF);

        // asynchronous reset in the middle of a scan
        a_clear_board();
        for (int i = 0; i < 6; i++) a_write(4'(i), 2'd1, 0, "a prefill6");
        a_req = 1; a_ai_id = 2'd2;
        cyc();
        a_req = 0;
        cyc();
        check("a busy before reset", a_busy, 1);
        #2 reset = 1;
        #1;
        foreach (ma[i]) ma[i] = 0;
        check("async reset board", a_board, pack_a());
        check("async reset flags", {a_busy, a_done, a_no_move, a_wr_err}, 4'b0000);
        check("async reset position", a_position, 0);
        #1 reset = 0;
        repeat (8) cyc();
        check("after reset no done", {a_done, a_busy}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ttt_move_engine.md
Name: ttt_move_engine

Overview:
Parametrised board-owning move engine for the tic-tac-toe game controller; next generation of the fixed-order "computer plays" block. Holds the board cell registers and accepts human moves over a write port. On request, it scans for a free cell from a pseudo-random or fixed start index, claims it for the machine player, and reports the position. It also reports the board-full condition and illegal writes, and supports any board size.

Parameters:
N_CELLS, 9, number of board cells (legal range 2..64)
ID_W, 2, player-ID width; ID 0 = empty cell
RANDOM_EN, 1, 1 = scan start from LFSR; 0 = scan always starts at cell 0
LFSR_SEED, 8'h01, LFSR value loaded at reset (must be nonzero)
POS_W, $clog2(N_CELLS), derived; not overridden

Ports:
clock     in   1                 clock
reset     in   1                 asynchronous, active-high reset
clear     in   1                 synchronous board clear and abort
wr_en     in   1                 human move strobe
wr_pos    in   POS_W             human move cell index
wr_id     in   ID_W              human player ID
wr_err    out  1                 1-cycle pulse: human move rejected
req       in   1                 request a machine move (level, sampled in IDLE)
ai_id     in   ID_W              machine player ID; sampled with req
busy      out  1                 scan in progress
done      out  1                 1-cycle pulse: request finished
no_move   out  1                 valid with done: board full, nothing written
position  out  POS_W             cell claimed; held until the next done
board     out  N_CELLS*ID_W      flattened cell contents; cell i at [i*ID_W +: ID_W]

Behaviour:
- Reset: all cells 0, position 0, done/no_move/wr_err/busy 0, FSM IDLE, lfsr=LFSR_SEED.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Advances every cycle, including while busy.
- FSM states are IDLE and SCAN. done is registered.
- IDLE, req=1 at edge t:
  - Latch ai_id.
  - idx <= RANDOM_EN ? lfsr % N_CELLS : 0.
  - cnt <= 0.
  - busy=1 from t+1.
- SCAN, one cell per cycle:
  - cell[idx]==0: cell[idx]<=ai_id, position<=idx, done=1, no_move=0, then IDLE.
  - Otherwise, if cnt==N_CELLS-1: done=1, no_move=1, position unchanged, then IDLE.
  - Otherwise: idx <= (idx==N_CELLS-1) ? 0 : idx+1, and cnt++.
- Latency: k-th cell examined free, so done is high in cycle t+k. Full board: done at t+N_CELLS.
- done and no_move are high for exactly one cycle. busy drops in the same cycle done rises.
- Human write is accepted only in IDLE. It is rejected with a wr_err pulse (next cycle, board unchanged) if any of these hold:
  - busy
  - wr_pos >= N_CELLS
  - wr_id==0
  - target cell nonzero
- Simultaneous wr_en and req in IDLE: the write commits at the same edge the request is accepted. The scan sees the updated board.
- clear (priority over everything except reset):
  - All cells <= 0 and FSM <= IDLE.
  - An in-flight scan is aborted with no done.
  - A same-cycle wr_en or req is ignored; no wr_err is raised.
  - position is held; the LFSR is not reset.
- req held high after done starts a new request the following cycle (back-to-back allowed).
- ai_id==0 is not checked; it is the user's responsibility.
- Asynchronous reset mid-scan returns everything to reset values immediately.

Decomposition:
- Package ttt_pkg contains:
  - typedef state_t {IDLE, SCAN}
  - EMPTY_ID = '0
  - LFSR_TAPS = 8'hB8
  - helper function cell_get(board, i)
- Sub-module ttt_lfsr8: free-running LFSR with seed parameter. Everything else stays in ttt_move_engine.

Test Plan:
- RANDOM_EN=0, empty board, req with ai_id=2 -> done at t+1, position=0, cell0=2, no_move=0.
- RANDOM_EN=0, human writes cells 0 and 1 with id 1, then req with ai_id=2 -> done at t+3, position=2, cell2=2.
- All 9 cells filled, then req -> busy for 9 cycles, done and no_move at t+9, board unchanged.
- Illegal human writes: occupied cell, wr_pos=9, wr_id=0, and a write while busy -> each gives a 1-cycle wr_err and the board is unchanged.
- Two clear cases:
  - clear asserted 2 cycles into a scan of a nearly full board -> no done, board all 0, FSM IDLE.
  - clear together with wr_en -> no write and no wr_err.
- RANDOM_EN=1 and N_CELLS=16, sparse board, 200 random reqs -> every claimed cell matches a model of LFSR%N followed by a wrapped forward scan; all 16 start indices are observed.
